// File: rtl/tff_count_sequencer_pkg.sv
// Shared types and step arithmetic for the toggle-flop count sequencer.
// Pure functions and typedefs only; no state, no handshakes.
package tff_count_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } state_t;

    function automatic int unsigned bin2gray(input int unsigned b);
        return b ^ (b >> 1);
    endfunction

    // Out-of-range counts (q > limit) fold back as if they had just wrapped.
    function automatic int unsigned next_count(input int unsigned q,
                                               input logic        up_dn,
                                               input int unsigned limit);
        if (up_dn)
            return (q >= limit) ? 32'd0 : q + 32'd1;
        return (q == 32'd0 || q > limit) ? limit : q - 32'd1;
    endfunction

    function automatic logic is_wrap(input int unsigned q,
                                     input logic        up_dn,
                                     input int unsigned limit);
        if (up_dn)
            return q >= limit;
        return (q == 32'd0) || (q > limit);
    endfunction

endpackage

// File: rtl/tff_count_sequencer_if.sv
// Command/status bundle between control logic and the count sequencer.
// Level commands in, count and status out; no backpressure.
interface tff_count_sequencer_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic             stop;
    logic             clear;
    logic             up_dn;
    logic             oneshot;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] t_en;
    logic             busy;
    logic             tc;
    logic             done;

    modport master (
        output start, stop, clear, up_dn, oneshot,
        input  q, t_en, busy, tc, done
    );

    modport slave (
        input  start, stop, clear, up_dn, oneshot,
        output q, t_en, busy, tc, done
    );
endinterface

// File: rtl/tff_count_sequencer_tff_cell.sv
// Single toggle flop: Q flips on each rising edge with T high; async active-high reset.
// One-cycle latency; no backpressure.
module tff_cell (
    input  logic clk,
    input  logic rst,
    input  logic t_i,
    output logic q_o
);
    logic q_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            q_q <= 1'b0;
        else if (t_i)
            q_q <= ~q_q;
    end

    assign q_o = q_q;
endmodule

// File: rtl/tff_count_sequencer.sv
// Start/stop up/down modulo-(LIMIT+1) counter built from a toggle-flop bank; one step per RUN edge,
// tc registered one cycle after a wrap. Define TFF_COUNT_GRAY_EN for a full-range Gray sequence.
module tff_count_sequencer
    import tff_count_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int LIMIT = 9
) (
    input  logic                  clk,
    input  logic                  rst,
    tff_count_sequencer_if.slave  bus
);
    state_t           state_q, state_d;
    logic             tc_q, tc_d;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] t_en;
    logic [WIDTH-1:0] step_vec;
    logic             step_wrap;

`ifdef TFF_COUNT_GRAY_EN
    // Binary shadow counter; the bank holds gray(b) so only one flop toggles per step.
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] b_next;

    assign b_next    = bus.up_dn ? b_q + WIDTH'(1) : b_q - WIDTH'(1);
    assign step_vec  = WIDTH'(bin2gray(32'(b_next)) ^ bin2gray(32'(b_q)));
    assign step_wrap = bus.up_dn ? (b_q == '1) : (b_q == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            b_q <= '0;
        else if (bus.clear)
            b_q <= '0;
        else if (state_q == RUN && !bus.stop)
            b_q <= b_next;
    end
`else
    logic [WIDTH-1:0] next_q;

    assign next_q    = WIDTH'(next_count(32'(q), bus.up_dn, LIMIT));
    assign step_vec  = q ^ next_q;
    assign step_wrap = is_wrap(32'(q), bus.up_dn, LIMIT);
`endif

    always_comb begin
        state_d = state_q;
        tc_d    = 1'b0;
        t_en    = '0;
        if (bus.clear) begin
            // Toggling every set bit drives the bank straight to zero.
            state_d = IDLE;
            t_en    = q;
        end else begin
            case (state_q)
                IDLE, HOLD, DONE: begin
                    if (bus.start && !bus.stop)
                        state_d = RUN;
                end
                RUN: begin
                    if (bus.stop) begin
                        state_d = HOLD;
                    end else begin
                        t_en = step_vec;
                        tc_d = step_wrap;
                        if (step_wrap && bus.oneshot)
                            state_d = DONE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        if (rst)
            t_en = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            tc_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            tc_q    <= tc_d;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        tff_cell u_cell (
            .clk (clk),
            .rst (rst),
            .t_i (t_en[i]),
            .q_o (q[i])
        );
    end

    assign bus.q    = q;
    assign bus.t_en = t_en;
    assign bus.busy = (state_q == RUN);
    assign bus.done = (state_q == DONE);
    assign bus.tc   = tc_q;
endmodule
